// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares port A of the data memory between requester 0 (core LSU) and
//   requester 1 (DMA/debug). It arbitrates round-robin and range-checks each
//   command against the active addressing mode. It tracks the fixed read
//   latency and returns a one-cycle completion pulse to the winner.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   mode                  1 = unified 64-bit, 0 = dual-core (sampled at grant)
//   rq_req/rq_we          per-requester request / write strobe
//   rq0_*/rq1_*           per-requester address, store data, access size
//   rq_unsigned           per-requester zero-extend for loads
//   rq_gnt                command captured (one-cycle pulse)
//   rq_done/rq_err        access complete / range fault (valid with done)
//   rq0_rdata/rq1_rdata   last load result per requester
//   mem_*                 memory port A command, mem_dout read data
//
// state  | meaning
// IDLE   | waiting for a request, arbitrates and captures the command
// ISSUE  | drives the memory command (suppressed on range fault)
// WAIT   | counts down the read latency
// DONE   | completion pulse to the winner
module dmem_port_arbiter #(
  parameter int READ_LAT      = 1,
  parameter int LIMIT_UNIFIED = 8192,
  parameter int LIMIT_DUAL    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic [1:0]  rq_req,
  input  logic [1:0]  rq_we,
  input  logic [63:0] rq0_addr,
  input  logic [63:0] rq1_addr,
  input  logic [63:0] rq0_wdata,
  input  logic [63:0] rq1_wdata,
  input  logic [1:0]  rq0_amt,
  input  logic [1:0]  rq1_amt,
  input  logic [1:0]  rq_unsigned,
  output logic [1:0]  rq_gnt,
  output logic [1:0]  rq_done,
  output logic [1:0]  rq_err,
  output logic [63:0] rq0_rdata,
  output logic [63:0] rq1_rdata,
  output logic        mem_ena,
  output logic        mem_wea,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [1:0]  mem_amt,
  output logic        mem_unsigned,
  input  logic [63:0] mem_dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0]  CNT_INIT  = 2'(READ_LAT - 1);
  localparam logic [64:0] LIM_UNI   = 65'(LIMIT_UNIFIED);
  localparam logic [64:0] LIM_DUAL  = 65'(LIMIT_DUAL);

  logic [1:0]  state;
  logic        last_grant;
  logic        win_q;
  logic        we_q;
  logic        err_q;
  logic        uns_q;
  logic [1:0]  amt_q;
  logic [1:0]  cnt_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] mem_addr_q;
  logic [63:0] rdata0_q;
  logic [63:0] rdata1_q;

  // Arbitration and command selection
  logic        win;
  logic        sel_we;
  logic        sel_uns;
  logic [1:0]  sel_amt;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;
  logic [63:0] eff_addr;
  logic [64:0] end_addr;
  logic        range_err;

  always_comb begin
    // On conflict the requester that did not win last time goes first.
    win       = (rq_req == 2'b11) ? ~last_grant : rq_req[1];
    sel_we    = win ? rq_we[1]       : rq_we[0];
    sel_uns   = win ? rq_unsigned[1] : rq_unsigned[0];
    sel_amt   = win ? rq1_amt        : rq0_amt;
    sel_addr  = win ? rq1_addr       : rq0_addr;
    sel_wdata = win ? rq1_wdata      : rq0_wdata;
    // Dual-core mode only decodes the low 32 address bits.
    eff_addr  = mode ? sel_addr : {32'd0, sel_addr[31:0]};
    // 65-bit end address so a wrap past 2^64 still counts as out of range.
    end_addr  = {1'b0, eff_addr} + (65'd1 << sel_amt) - 65'd1;
    range_err = mode ? (end_addr >= LIM_UNI) : (end_addr >= LIM_DUAL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      uns_q      <= 1'b0;
      amt_q      <= 2'd0;
      cnt_q      <= 2'd0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      mem_addr_q <= 64'd0;
      rdata0_q   <= 64'd0;
      rdata1_q   <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|rq_req) begin
            state      <= S_ISSUE;
            win_q      <= win;
            last_grant <= win;
            we_q       <= sel_we;
            uns_q      <= sel_uns;
            amt_q      <= sel_amt;
            addr_q     <= eff_addr;
            wdata_q    <= sel_wdata;
            err_q      <= range_err;
          end
        end
        S_ISSUE: begin
          if (!err_q) mem_addr_q <= addr_q;
          if (err_q || we_q) begin
            state <= S_DONE;
          end else begin
            state <= S_WAIT;
            cnt_q <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            state <= S_DONE;
            if (win_q) rdata1_q <= mem_dout;
            else       rdata0_q <= mem_dout;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic issue_ok;
  logic [1:0] win_vec;

  always_comb begin
    issue_ok     = (state == S_ISSUE) && !err_q;
    win_vec      = win_q ? 2'b10 : 2'b01;
    rq_gnt       = (state == S_ISSUE) ? win_vec : 2'b00;
    rq_done      = (state == S_DONE)  ? win_vec : 2'b00;
    rq_err       = (state == S_DONE && err_q) ? win_vec : 2'b00;
    mem_ena      = issue_ok;
    mem_wea      = issue_ok & we_q;
    // Address holds its last issued value while the port is idle.
    mem_addr     = issue_ok ? addr_q : mem_addr_q;
    mem_wdata    = issue_ok ? wdata_q : 64'd0;
    mem_amt      = issue_ok ? amt_q : 2'd0;
    mem_unsigned = issue_ok & uns_q;
  end

  assign rq0_rdata = rdata0_q;
  assign rq1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  rq_req, rq_req3, rq_we, rq_unsigned;
  logic [63:0] rq0_addr, rq1_addr, rq0_wdata, rq1_wdata;
  logic [1:0]  rq0_amt, rq1_amt;
  logic [1:0]  rq_gnt, rq_done, rq_err;
  logic [63:0] rq0_rdata, rq1_rdata;
  logic        mem_ena, mem_wea, mem_unsigned;
  logic [63:0] mem_addr, mem_wdata, mem_dout;
  logic [1:0]  mem_amt;

  logic [1:0]  gnt3, done3, err3;
  logic [63:0] rd0_3, rd1_3;
  logic        ena3, wea3, uns3;
  logic [63:0] addr3, wdata3;
  logic [1:0]  amt3;
  logic [63:0] mem_dout3;

  int tests = 0;
  int fails = 0;
  logic [31:0] cyc = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .rq_req(rq_req), .rq_we(rq_we),
    .rq0_addr(rq0_addr), .rq1_addr(rq1_addr), .rq0_wdata(rq0_wdata), .rq1_wdata(rq1_wdata),
    .rq0_amt(rq0_amt), .rq1_amt(rq1_amt), .rq_unsigned(rq_unsigned),
    .rq_gnt(rq_gnt), .rq_done(rq_done), .rq_err(rq_err),
    .rq0_rdata(rq0_rdata), .rq1_rdata(rq1_rdata),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_amt(mem_amt), .mem_unsigned(mem_unsigned), .mem_dout(mem_dout)
  );

  dmem_port_arbiter #(.READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .rq_req(rq_req3), .rq_we(rq_we),
    .rq0_addr(rq0_addr), .rq1_addr(rq1_addr), .rq0_wdata(rq0_wdata), .rq1_wdata(rq1_wdata),
    .rq0_amt(rq0_amt), .rq1_amt(rq1_amt), .rq_unsigned(rq_unsigned),
    .rq_gnt(gnt3), .rq_done(done3), .rq_err(err3),
    .rq0_rdata(rd0_3), .rq1_rdata(rd1_3),
    .mem_ena(ena3), .mem_wea(wea3), .mem_addr(addr3), .mem_wdata(wdata3),
    .mem_amt(amt3), .mem_unsigned(uns3), .mem_dout(mem_dout3)
  );

  // Memory model for the READ_LAT=1 instance: little-endian bytes,
  // read data valid the cycle after ena.
  logic [7:0] mem [0:8191];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_dout3 <= {32'hC0DE_0000, cyc};
    if (mem_ena) begin
      int n;
      logic [63:0] v;
      n = 1 << mem_amt;
      if (mem_wea) begin
        for (int i = 0; i < n; i++)
          mem[(mem_addr[12:0] + 13'(i))] = mem_wdata[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < n; i++)
          v[8*i +: 8] = mem[(mem_addr[12:0] + 13'(i))];
        if (!mem_unsigned && n < 8 && v[8*n-1])
          v = v | ~((64'd1 << (8*n)) - 64'd1);
        mem_dout <= v;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [63:0] addr;
    logic [1:0]  amt;
    logic [1:0]  uns;
    logic        mode;
    logic [63:0] wdata;
    logic        exp_win;
    int          exp_dk;
    logic        exp_err;
    logic        exp_ena;
    logic        chk_rd;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic run_txn(input vec_t v, output int g_k, output logic [1:0] g_val,
                         output int d_k, output logic [1:0] d_val, output logic [1:0] e_val,
                         output logic ena_seen, output logic wea_seen, output logic [63:0] rd);
    @(posedge clk); #1;
    rq_req = v.req; rq_we = v.we; rq0_addr = v.addr; rq1_addr = v.addr;
    rq0_amt = v.amt; rq1_amt = v.amt; rq_unsigned = v.uns; mode = v.mode;
    rq0_wdata = v.wdata; rq1_wdata = v.wdata;
    g_k = -1; d_k = -1; g_val = 0; d_val = 0; e_val = 0;
    ena_seen = 0; wea_seen = 0; rd = 0;
    for (int k = 0; k < 12 && d_k < 0; k++) begin
      @(negedge clk);
      if (rq_gnt != 0 && g_k < 0) begin g_k = k; g_val = rq_gnt; end
      if (mem_ena) begin ena_seen = 1; wea_seen = mem_wea; end
      if (rq_done != 0) begin
        d_k = k; d_val = rq_done; e_val = rq_err;
        rd = rq_done[1] ? rq1_rdata : rq0_rdata;
      end
      @(posedge clk); #1;
      if (g_k >= 0) rq_req = 2'b00;
    end
    rq_req = 2'b00;
  endtask

  initial begin
    int g_k, d_k;
    logic [1:0] g_val, d_val, e_val, wv;
    logic ena_seen, wea_seen;
    logic [63:0] rd, samp;
    logic [63:0] pat;
    int w_idx;
    logic last_w;
    logic dup;
    logic any_done;

    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    pat = 64'h1122_3344_5566_7788;
    for (int i = 0; i < 8; i++) mem[16'h10 + i] = pat[8*i +: 8];
    pat = 64'h0102_0304_0506_0708;
    for (int i = 0; i < 8; i++) mem[16'hFF8 + i] = pat[8*i +: 8];
    mem[16'h20] = 8'h9C;
    mem_dout = 64'd0;

    //           req    we     addr                    amt   uns    md wdata  win dk er ena chk rd
    vecs[0]  = '{2'b01, 2'b00, 64'h10,                 2'd3, 2'b00, 1, 64'h0,  0, 3, 0, 1, 1, 64'h1122_3344_5566_7788};
    vecs[1]  = '{2'b10, 2'b10, 64'h3,                  2'd1, 2'b00, 1, 64'hBEEF, 1, 2, 0, 1, 0, 64'h0};
    vecs[2]  = '{2'b01, 2'b00, 64'h3,                  2'd1, 2'b01, 1, 64'h0,  0, 3, 0, 1, 1, 64'hBEEF};
    vecs[3]  = '{2'b01, 2'b00, 64'h3,                  2'd1, 2'b00, 1, 64'h0,  0, 3, 0, 1, 1, 64'hFFFF_FFFF_FFFF_BEEF};
    vecs[4]  = '{2'b01, 2'b00, 64'h1FFC,               2'd3, 2'b00, 1, 64'h0,  0, 2, 1, 0, 1, 64'hFFFF_FFFF_FFFF_BEEF};
    vecs[5]  = '{2'b01, 2'b00, 64'hFF8,                2'd3, 2'b00, 0, 64'h0,  0, 3, 0, 1, 1, 64'h0102_0304_0506_0708};
    vecs[6]  = '{2'b01, 2'b00, 64'hFFC,                2'd3, 2'b00, 0, 64'h0,  0, 2, 1, 0, 0, 64'h0};
    vecs[7]  = '{2'b01, 2'b00, 64'hFFFF_FFFF_0000_0020, 2'd0, 2'b00, 0, 64'h0,  0, 3, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FF9C};
    vecs[8]  = '{2'b01, 2'b00, 64'hFFFF_FFFF_0000_0020, 2'd0, 2'b00, 1, 64'h0,  0, 2, 1, 0, 0, 64'h0};
    vecs[9]  = '{2'b10, 2'b10, 64'h1FFF,               2'd0, 2'b00, 1, 64'h5A, 1, 2, 0, 1, 0, 64'h0};
    vecs[10] = '{2'b10, 2'b10, 64'h1FFF,               2'd1, 2'b00, 1, 64'h77, 1, 2, 1, 0, 0, 64'h0};
    vecs[11] = '{2'b10, 2'b00, 64'h1FFF,               2'd0, 2'b10, 1, 64'h0,  1, 3, 0, 1, 1, 64'h5A};
    vecs[12] = '{2'b01, 2'b00, 64'hFFF,                2'd0, 2'b00, 0, 64'h0,  0, 3, 0, 1, 1, 64'h01};

    rst_n = 0; mode = 1; rq_req = 0; rq_req3 = 0; rq_we = 0; rq_unsigned = 0;
    rq0_addr = 0; rq1_addr = 0; rq0_wdata = 0; rq1_wdata = 0; rq0_amt = 0; rq1_amt = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_ctrl", 64'({rq_gnt, rq_done, rq_err, mem_ena, mem_wea, mem_amt, mem_unsigned}), 64'd0);
    check("reset_data", mem_addr | mem_wdata | rq0_rdata | rq1_rdata, 64'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // READ_LAT=3 instance: done at T+5, rdata equals mem_dout seen at T+4.
    @(posedge clk); #1;
    rq_req3 = 2'b01; rq_we = 2'b00; rq0_addr = 64'h10; rq0_amt = 2'd3; mode = 1;
    g_k = -1; d_k = -1; samp = 0; rd = 0; w_idx = -1;
    for (int k = 0; k < 12 && d_k < 0; k++) begin
      @(negedge clk);
      if (gnt3 != 0 && g_k < 0) g_k = k;
      if (ena3 && w_idx < 0) w_idx = k;
      if (k == 4) samp = mem_dout3;
      if (done3 != 0) begin d_k = k; rd = rd0_3; end
      @(posedge clk); #1;
      if (g_k >= 0) rq_req3 = 2'b00;
    end
    rq_req3 = 2'b00;
    check("lat3_gnt_cycle", 64'(g_k), 64'd1);
    check("lat3_ena_cycle", 64'(w_idx), 64'd1);
    check("lat3_done_cycle", 64'(d_k), 64'd5);
    check("lat3_rdata", rd, samp);

    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i], g_k, g_val, d_k, d_val, e_val, ena_seen, wea_seen, rd);
      wv = vecs[i].exp_win ? 2'b10 : 2'b01;
      check($sformatf("v%0d_gnt_cycle", i), 64'(g_k), 64'd1);
      check($sformatf("v%0d_gnt", i), 64'(g_val), 64'(wv));
      check($sformatf("v%0d_done_cycle", i), 64'(d_k), 64'(vecs[i].exp_dk));
      check($sformatf("v%0d_done", i), 64'(d_val), 64'(wv));
      check($sformatf("v%0d_err", i), 64'(e_val), vecs[i].exp_err ? 64'(wv) : 64'd0);
      check($sformatf("v%0d_ena", i), 64'(ena_seen), 64'(vecs[i].exp_ena));
      if (vecs[i].exp_ena)
        check($sformatf("v%0d_wea", i), 64'(wea_seen), 64'(vecs[i].we != 0));
      if (vecs[i].chk_rd)
        check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Reset while the read sits in WAIT: no done, everything cleared.
    @(posedge clk); #1;
    rq_req = 2'b01; rq_we = 0; rq0_addr = 64'h10; rq0_amt = 2'd3; rq_unsigned = 0; mode = 1;
    @(posedge clk); #1;
    rq_req = 2'b00;
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    check("midrst_ctrl", 64'({rq_gnt, rq_done, rq_err, mem_ena, mem_wea, mem_amt, mem_unsigned}), 64'd0);
    check("midrst_data", mem_addr | mem_wdata | rq0_rdata | rq1_rdata, 64'd0);
    rst_n = 1;
    any_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rq_done != 0) any_done = 1;
    end
    check("midrst_no_done", 64'(any_done), 64'd0);
    run_txn(vecs[0], g_k, g_val, d_k, d_val, e_val, ena_seen, wea_seen, rd);
    check("post_rst_gnt_cycle", 64'(g_k), 64'd1);
    check("post_rst_rdata", rd, 64'h1122_3344_5566_7788);

    // Both requesting continuously after reset: grants alternate 0,1,0,1.
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    rq_we = 0; rq0_addr = 0; rq1_addr = 0; rq0_amt = 0; rq1_amt = 0; mode = 1;
    rq_req = 2'b11;
    w_idx = 0; dup = 0; last_w = 1'bx;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (rq_gnt != 0) begin
        if (w_idx < 4)
          check($sformatf("rr_grant%0d", w_idx), 64'(rq_gnt), (w_idx % 2 == 0) ? 64'd1 : 64'd2);
        if (w_idx > 0 && rq_gnt[1] == last_w) dup = 1;
        last_w = rq_gnt[1];
        w_idx++;
      end
    end
    rq_req = 2'b00;
    check("rr_grant_count_ge4", 64'(w_idx >= 4), 64'd1);
    check("rr_no_repeat", 64'(dup), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
